// File: rtl/ps2_square_pkg.sv
// ps2_square_pkg: shared scan codes, decoder states, held-bit indices and step helper
// Used by ps2_square_mover; no ports.
package ps2_square_pkg;

   localparam logic [7:0] SC_E0    = 8'hE0;
   localparam logic [7:0] SC_F0    = 8'hF0;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;

   localparam int K_UP    = 0;
   localparam int K_DOWN  = 1;
   localparam int K_LEFT  = 2;
   localparam int K_RIGHT = 3;

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} dec_state_t;

   // One-hot {RIGHT, LEFT, DOWN, UP}; zero for non-arrow bytes.
   function automatic logic [3:0] arrow_onehot(input logic [7:0] b);
      arrow_onehot = {b == SC_RIGHT, b == SC_LEFT, b == SC_DOWN, b == SC_UP};
   endfunction

   // Saturating step along one axis; opposing requests cancel.
   function automatic logic [9:0] step_axis(input logic [9:0] v, input logic dec, input logic inc,
                                            input logic [9:0] step, input logic [9:0] max);
      logic [10:0] sum;
      sum = {1'b0, v} + {1'b0, step};
      step_axis = (dec & ~inc) ? ((v >= step) ? v - step : '0) :
                  (inc & ~dec) ? ((sum > {1'b0, max}) ? max : sum[9:0]) : v;
   endfunction

endpackage

// File: rtl/ps2_square_mover_if.sv
// ps2_square_mover_if: PS/2 byte input and square-position outputs
// ps2_out/ps2_key_pressed: raw receiver byte and async valid flag
// oX_squre/oY_squre: square top row / left column; oMove: moved pulse; oKeys_held: {R,L,D,U}
interface ps2_square_mover_if;
   logic [7:0] ps2_out;
   logic       ps2_key_pressed;
   logic [9:0] oX_squre;
   logic [9:0] oY_squre;
   logic       oMove;
   logic [3:0] oKeys_held;
   modport master (output ps2_out, ps2_key_pressed, input oX_squre, oY_squre, oMove, oKeys_held);
   modport slave  (input ps2_out, ps2_key_pressed, output oX_squre, oY_squre, oMove, oKeys_held);
endinterface

// File: rtl/ps2_byte_sync.sv
// ps2_byte_sync: brings the PS/2 byte-valid flag into iVGA_CLK and captures the byte
// iVGA_CLK, iRST_n (async active-low); ps2_key_pressed/ps2_out in;
// byte_stb: one-cycle strobe 3 cycles after flag rise; byte_q: byte valid while byte_stb
module ps2_byte_sync (
   input  logic       iVGA_CLK,
   input  logic       iRST_n,
   input  logic       ps2_key_pressed,
   input  logic [7:0] ps2_out,
   output logic       byte_stb,
   output logic [7:0] byte_q
);
   // sync[1:0] is the two-flop synchronizer, sync[2] the edge-detect history
   logic [2:0] sync;
   always_ff @(posedge iVGA_CLK or negedge iRST_n)
      if (!iRST_n) begin
         sync     <= '0;
         byte_stb <= 1'b0;
         byte_q   <= '0;
      end else begin
         sync     <= {sync[1:0], ps2_key_pressed};
         byte_stb <= sync[1] & ~sync[2];
         if (sync[1] & ~sync[2]) byte_q <= ps2_out;
      end
endmodule

// File: rtl/ps2_square_mover.sv
// ps2_square_mover: decodes PS/2 arrow make/break codes into held keys and a clamped square position
// iVGA_CLK, iRST_n (async active-low); bus (slave): ps2_out/ps2_key_pressed in,
// oX_squre/oY_squre/oMove/oKeys_held out.
// Build option PS2_AUTOREPEAT_EN: internal auto-repeat counter, keyboard typematic makes ignored.
module ps2_square_mover
   import ps2_square_pkg::*;
#(
   parameter int STEP   = 5,
   parameter int X_MAX  = 427,
   parameter int Y_MAX  = 600,
   parameter int X_INIT = 220,
   parameter int Y_INIT = 300
`ifdef PS2_AUTOREPEAT_EN
   ,parameter int REPEAT_DELAY = 12_500_000,
   parameter int REPEAT_RATE  = 2_500_000
`endif
) (
   input logic iVGA_CLK,
   input logic iRST_n,
   ps2_square_mover_if.slave bus
);
   logic       byte_stb;
   logic [7:0] byte_q;
   dec_state_t st, st_n;
   logic [3:0] held, held_n, arrow, imm, stp;
   logic       make, brk;
   logic [9:0] x, y, x_n, y_n;
   logic       chg, move;

   ps2_byte_sync u_sync (
      .iVGA_CLK        (iVGA_CLK),
      .iRST_n          (iRST_n),
      .ps2_key_pressed (bus.ps2_key_pressed),
      .ps2_out         (bus.ps2_out),
      .byte_stb        (byte_stb),
      .byte_q          (byte_q)
   );

   always_comb begin
      arrow  = arrow_onehot(byte_q);
      make   = byte_stb && (st == IDLE || st == EXT) && |arrow;
      brk    = byte_stb && (st == BRK || st == EXT_BRK) && |arrow;
      st_n   = !byte_stb ? st :
               (byte_q == SC_F0 && st == IDLE) ? BRK :
               (byte_q == SC_F0 && st == EXT)  ? EXT_BRK :
               (byte_q == SC_E0 && st == IDLE) ? EXT : IDLE;
      held_n = make ? held | arrow : brk ? held & ~arrow : held;
   end

`ifdef PS2_AUTOREPEAT_EN
   localparam int CNT_W = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             expire;
   // A fresh make takes priority over an expiry in the same cycle and restarts the delay.
   always_comb begin
      imm    = make ? arrow & ~held : 4'b0;
      expire = |held && cnt <= CNT_W'(1);
      stp    = |imm ? imm : expire ? held : 4'b0;
      cnt_n  = |imm ? CNT_W'(REPEAT_DELAY) : !(|held) ? '0 :
               expire ? CNT_W'(REPEAT_RATE) : cnt - CNT_W'(1);
   end
   always_ff @(posedge iVGA_CLK or negedge iRST_n)
      if (!iRST_n) cnt <= '0;
      else cnt <= cnt_n;
`else
   // Every arrow make steps, so keyboard typematic drives repetition.
   always_comb begin
      imm = make ? arrow : 4'b0;
      stp = imm;
   end
`endif

   assign x_n = step_axis(x, stp[K_UP], stp[K_DOWN], 10'(STEP), 10'(X_MAX));
   assign y_n = step_axis(y, stp[K_LEFT], stp[K_RIGHT], 10'(STEP), 10'(Y_MAX));

   // chg marks the cycle a coordinate changed; move trails it by one cycle.
   always_ff @(posedge iVGA_CLK or negedge iRST_n)
      if (!iRST_n) begin
         st   <= IDLE;
         held <= '0;
         x    <= 10'(X_INIT);
         y    <= 10'(Y_INIT);
         chg  <= 1'b0;
         move <= 1'b0;
      end else begin
         st   <= st_n;
         held <= held_n;
         x    <= x_n;
         y    <= y_n;
         chg  <= (x_n != x) || (y_n != y);
         move <= chg;
      end

   assign bus.oX_squre   = x;
   assign bus.oY_squre   = y;
   assign bus.oMove      = move;
   assign bus.oKeys_held = held;
endmodule
